uart_rx_os: RTL

- Oversampling UART receiver; successor to the team's single-sample receiver.
- Adds:
  - 2-FF input synchroniser.
  - Internal baud/oversample tick generator, so the block runs directly on the system clock.
  - Start-bit glitch rejection and 3-sample majority vote per bit.
  - Runtime parity-error and framing-error flags.
  - Break handling.
- Sits between the board RX pin and user logic; the output handshake is a 1-cycle valid pulse.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_os.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, receiver FSM encoding and the
// oversample divider calculation (also used by the matching transmitter).
package uart_pkg;

  localparam int UART_CHK_NONE = 0;
  localparam int UART_CHK_ODD  = 1;
  localparam int UART_CHK_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_e;

  // System clocks per oversample tick, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    longint den;
    den = longint'(baud) * longint'(os);
    return int'((longint'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   i_clk    system clock
//   i_rst    async active-high reset
//   i_clear  restarts the divider so the next tick is a full period away
//   o_tick   one-cycle pulse every DIV clocks
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK    = 50_000_000,
  parameter int P_UART_BAUDRATE = 9600,
  parameter int P_OVERSAMPLE    = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int DIV = uart_div(P_SYSTEM_CLK, P_UART_BAUDRATE, P_OVERSAMPLE);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_baud_tick: divider below 2, system clock too slow for baud*oversample");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clear || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, parity/framing
// flags and break handling.
//   i_clk, i_rst       system clock, async active-high reset
//   i_uart_rx          async serial line (idle high)
//   o_user_rx_data     last received word, first line bit in bit0
//   o_user_rx_valid    one-cycle pulse per completed frame
//   o_parity_err       parity mismatch, only with valid
//   o_frame_err        a stop bit sampled low, only with valid
//   o_busy             receiver not idle
//
// state     | meaning
// ST_IDLE   | waiting for falling edge on rx_s
// ST_START  | checking start bit, glitch returns to idle
// ST_DATA   | shifting in data bits, LSB first
// ST_PARITY | comparing parity bit
// ST_STOP   | sampling stop bit(s), frame ends at last stop-bit vote
// ST_BREAK  | line held low after a zero stop bit, waiting for high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BAUDRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0,
  parameter int P_OVERSAMPLE      = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_busy
);

  localparam int W   = P_UART_DATA_WIDTH;
  localparam int M   = P_OVERSAMPLE / 2;
  localparam int OSW = $clog2(P_OVERSAMPLE);
  localparam int BW  = $clog2(W);
  localparam logic [OSW-1:0] OS_S0   = OSW'(M - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(M);
  localparam logic [OSW-1:0] OS_S2   = OSW'(M + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(P_OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(W - 1);
  localparam logic           STOP_LAST = 1'(P_UART_STOP_WIDTH - 1);

  generate
    if (W < 5 || W > 9) begin : g_w_chk
      $error("uart_rx_os: data width must be 5..9");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_s_chk
      $error("uart_rx_os: stop width must be 1 or 2");
    end
    if (P_UART_CHECK < 0 || P_UART_CHECK > 2) begin : g_c_chk
      $error("uart_rx_os: parity mode must be 0, 1 or 2");
    end
    if (P_OVERSAMPLE < 8 || (P_OVERSAMPLE % 2) != 0) begin : g_o_chk
      $error("uart_rx_os: oversample must be even and at least 8");
    end
  endgenerate

  logic rx_meta_q, rx_s_q;
  logic tick, clear;

  uart_rx_state_e state_q, state_d;
  logic [OSW-1:0] os_cnt_q, os_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           stop_cnt_q, stop_cnt_d;
  logic [1:0]     samp_q, samp_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_acc_q, par_acc_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           valid_q, valid_d;
  logic           pe_out_q, pe_out_d;
  logic           fe_out_q, fe_out_d;

  logic vote, at_mid, at_end, par_exp;

  uart_baud_tick #(
    .P_SYSTEM_CLK   (P_SYSTEM_CLK),
    .P_UART_BAUDRATE(P_UART_BAUDRATE),
    .P_OVERSAMPLE   (P_OVERSAMPLE)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(clear),
    .o_tick (tick)
  );

  // Third sample is the live rx_s at the decision tick.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_mid  = tick && (os_cnt_q == OS_S2);
  assign at_end  = tick && (os_cnt_q == OS_LAST);
  assign par_exp = (P_UART_CHECK == UART_CHK_EVEN) ? par_acc_q : ~par_acc_q;

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    pe_out_d   = 1'b0;
    fe_out_d   = 1'b0;
    clear      = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_BREAK && tick) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == OS_S0) samp_d[0] = rx_s_q;
      if (os_cnt_q == OS_S1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d    = ST_START;
          clear      = 1'b1;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_acc_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (at_mid && vote) state_d = ST_IDLE;
        else if (at_end)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_mid) begin
          shift_d   = {vote, shift_q[W-1:1]};
          par_acc_d = par_acc_q ^ vote;
        end else if (at_end) begin
          if (bit_cnt_q == BIT_LAST)
            state_d = (P_UART_CHECK != UART_CHK_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (at_mid) begin
          if (vote != par_exp) perr_d = 1'b1;
        end else if (at_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_mid) begin
          if (!vote) ferr_d = 1'b1;
          // Frame closes at the last stop-bit vote so the next start edge
          // can be caught even if the sender runs fast.
          if (stop_cnt_q == STOP_LAST) begin
            valid_d    = 1'b1;
            data_out_d = shift_q;
            pe_out_d   = perr_q;
            fe_out_d   = ferr_q | ~vote;
            state_d    = (!vote && !rx_s_q) ? ST_BREAK : ST_IDLE;
          end
        end else if (at_end) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      pe_out_q   <= 1'b0;
      fe_out_q   <= 1'b0;
    end else begin
      rx_meta_q  <= i_uart_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      pe_out_q   <= pe_out_d;
      fe_out_q   <= fe_out_d;
    end
  end

  assign o_user_rx_data  = data_out_q;
  assign o_user_rx_valid = valid_q;
  assign o_parity_err    = pe_out_q;
  assign o_frame_err     = fe_out_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule
